leaf_user_stream_fifo: RTL and testbench

//  Elastic buffer between the leaf_interface user-side output stream (dout/vld/ack) and the user kernel

---
 rtl/leaf_user_stream_fifo.sv | 116 +++++++++++
 tb/tb_leaf_user_stream_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_user_stream_fifo.sv
// Elastic buffer between the leaf_interface user stream and a user kernel input port.
// Latency: a word pushed into an empty buffer appears on dout/vld_out one cycle after the push.
// Backpressure: ack_out is a registered !full and never depends on vld_in or ack_in in the same cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   din, vld_in, ack_out    upstream side (leaf_interface dout/vld, ack back to it)
//   dout, vld_out, ack_in   downstream side (kernel Input_N_V_V, _ap_vld, _ap_ack)
//   count               occupancy 0..2**DEPTH_BITS
//   almost_full         count >= AFULL_LEVEL
//   words_out           words delivered to the kernel since reset, modulo 2**32
module leaf_user_stream_fifo #(
  parameter int PAYLOAD_BITS = 32,
  parameter int DEPTH_BITS   = 4,
  parameter int AFULL_LEVEL  = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    vld_in,
  output logic                    ack_out,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    vld_out,
  input  logic                    ack_in,
  output logic [DEPTH_BITS:0]     count,
  output logic                    almost_full,
  output logic [31:0]             words_out
);

  localparam int                    DEPTH     = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   DEPTH_CNT = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]   AFULL_CNT = (DEPTH_BITS+1)'(AFULL_LEVEL);
  localparam logic [DEPTH_BITS:0]   CNT_ONE   = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE   = DEPTH_BITS'(1);

  // Storage is never reset; only pointers and count define what is valid.
  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];

  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  ack_q, ack_d;
  logic                  afull_q, afull_d;
  logic [31:0]           words_q, words_d;

  logic not_empty;
  logic push;
  logic pop;

  assign not_empty = (count_q != '0);

  // A handshake only counts when both sides agree in the same cycle. Since
  // ack_q is low whenever the buffer is full, there is no pass-through path.
  assign push = vld_in & ack_q;
  assign pop  = not_empty & ack_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    words_d  = words_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      words_d  = words_q + 32'd1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Both flags follow the next-state count so they change in the same
    // cycle the count output does.
    ack_d   = (count_d != DEPTH_CNT);
    afull_d = (count_d >= AFULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      afull_q  <= 1'b0;
      words_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      afull_q  <= afull_d;
      words_q  <= words_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Asynchronous head read: the slot under rd_ptr_q cannot be overwritten
  // while it is valid, so dout holds steady until the word is consumed.
  assign dout        = mem_q[rd_ptr_q];
  assign vld_out     = not_empty;
  assign ack_out     = ack_q;
  assign count       = count_q;
  assign almost_full = afull_q;
  assign words_out   = words_q;

endmodule

// File: tb/tb_leaf_user_stream_fifo.sv
module tb_leaf_user_stream_fifo;

  logic        clk;
  logic        reset;
  logic [31:0] din;
  logic        vld_in;
  logic        ack_out;
  logic [31:0] dout;
  logic        vld_out;
  logic        ack_in;
  logic [4:0]  count;
  logic        almost_full;
  logic [31:0] words_out;

  int vectors;
  int miscompares;
  int n_popped;

  // Reference model: ordered queue of buffered words plus registered ack.
  logic [31:0] m_q[$];
  logic        m_ack;
  logic [31:0] m_words;

  leaf_user_stream_fifo #(
    .PAYLOAD_BITS(32),
    .DEPTH_BITS  (4),
    .AFULL_LEVEL (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .vld_in     (vld_in),
    .ack_out    (ack_out),
    .dout       (dout),
    .vld_out    (vld_out),
    .ack_in     (ack_in),
    .count      (count),
    .almost_full(almost_full),
    .words_out  (words_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("vld_out", {31'd0, vld_out}, {31'd0, m_q.size() != 0});
    chk("ack_out", {31'd0, ack_out}, {31'd0, m_ack});
    chk("count", {27'd0, count}, 32'(m_q.size()));
    chk("almost_full", {31'd0, almost_full}, {31'd0, m_q.size() >= 12});
    chk("words_out", words_out, m_words);
    if (m_q.size() != 0) chk("dout_head", dout, m_q[0]);
  endtask

  // One clock: decide handshakes from the model, advance, then compare.
  task automatic tick();
    logic        push;
    logic        pop;
    logic [31:0] d;
    logic [31:0] popped;
    push = vld_in && m_ack && !reset;
    pop  = (m_q.size() != 0) && ack_in && !reset;
    d    = din;
    if (pop) chk("dout_at_pop", dout, m_q[0]);
    @(posedge clk);
    #1;
    if (reset) begin
      m_q.delete();
      m_ack   = 1'b0;
      m_words = 32'd0;
    end else begin
      if (pop) begin
        popped = m_q.pop_front();
        m_words = m_words + 32'd1;
        n_popped++;
      end
      if (push) m_q.push_back(d);
      m_ack = (m_q.size() != 16);
    end
    chk_state();
  endtask

  initial begin
    int start_pops;
    int budget;
    vectors     = 0;
    miscompares = 0;
    n_popped    = 0;
    m_ack       = 1'b0;
    m_words     = 32'd0;
    reset       = 1'b1;
    din         = 32'd0;
    vld_in      = 1'b0;
    ack_in      = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_vld_out", {31'd0, vld_out}, 32'd0);
    chk("rst_ack_out", {31'd0, ack_out}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_words", words_out, 32'd0);
    reset = 1'b0;
    tick();
    chk("ack_after_rst", {31'd0, ack_out}, 32'd1);

    // Single word through an empty buffer
    din    = 32'hA5A5_0001;
    vld_in = 1'b1;
    ack_in = 1'b1;
    tick();
    vld_in = 1'b0;
    chk("t1_vld_out", {31'd0, vld_out}, 32'd1);
    chk("t1_dout", dout, 32'hA5A5_0001);
    chk("t1_count1", {27'd0, count}, 32'd1);
    tick();
    chk("t1_count0", {27'd0, count}, 32'd0);
    chk("t1_words", words_out, 32'd1);
    chk("t1_vld_low", {31'd0, vld_out}, 32'd0);

    // Fill to full with the kernel stalled
    ack_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din    = 32'(i);
      vld_in = 1'b1;
      tick();
      chk("t2_afull", {31'd0, almost_full}, {31'd0, (i + 1) >= 12});
    end
    chk("t2_count16", {27'd0, count}, 32'd16);
    chk("t2_ack_full", {31'd0, ack_out}, 32'd0);
    din = 32'h0000_0099;
    tick();
    vld_in = 1'b0;
    chk("t2_no_17th", {27'd0, count}, 32'd16);

    // Drain from full in order
    ack_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_order", dout, 32'(i));
      tick();
      if (i == 0) chk("t3_ack_back", {31'd0, ack_out}, 32'd1);
    end
    ack_in = 1'b0;
    chk("t3_empty", {27'd0, count}, 32'd0);
    chk("t3_words", words_out, 32'd17);

    // Steady push+pop at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) begin
      din    = 32'(100 + i);
      vld_in = 1'b1;
      tick();
    end
    ack_in = 1'b1;
    for (int k = 0; k < 100; k++) begin
      din = 32'(105 + k);
      chk("t4_order", dout, 32'(100 + k));
      tick();
      chk("t4_count5", {27'd0, count}, 32'd5);
    end
    vld_in = 1'b0;
    ack_in = 1'b0;

    // Random handshakes, 10k words delivered
    start_pops = n_popped;
    budget     = 0;
    while ((n_popped - start_pops) < 10000 && budget < 60000) begin
      vld_in = 1'($urandom_range(0, 1));
      ack_in = 1'($urandom_range(0, 1));
      din    = $urandom;
      tick();
      budget++;
    end
    vld_in = 1'b0;
    ack_in = 1'b0;
    chk("t5_done_in_budget", {31'd0, (n_popped - start_pops) >= 10000}, 32'd1);

    // Reset mid-operation at count 9
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      din    = 32'(200 + i);
      vld_in = 1'b1;
      tick();
    end
    vld_in = 1'b0;
    chk("t6_count9", {27'd0, count}, 32'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_count", {27'd0, count}, 32'd0);
    chk("t6_rst_vld", {31'd0, vld_out}, 32'd0);
    chk("t6_rst_words", words_out, 32'd0);
    tick();
    chk("t6_ack_back", {31'd0, ack_out}, 32'd1);
    din    = 32'hDEAD_BEEF;
    vld_in = 1'b1;
    tick();
    vld_in = 1'b0;
    chk("t6_fresh_vld", {31'd0, vld_out}, 32'd1);
    chk("t6_fresh_dout", dout, 32'hDEAD_BEEF);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("t6_fresh_words", words_out, 32'd1);
    chk("t6_fresh_count", {27'd0, count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
